fb_port_arbiter: RTL and testbench

Arbitrates the single read/write port of the framebuffer BRAM between the capture write stream and the display read stream. Sits between the capture-side clock-crossing FIFO and the display interface inside the memory subsystem. Maintains the framebuffer write address with wrap at end of frame, and issues one registered memory command per cycle. Display reads normally win; an optional guard bounds write starvation.

---
 rtl/fb_port_arbiter_if.sv | 35 +++
 rtl/fb_port_arbiter.sv | 124 ++++++++++++
 tb/tb_fb_port_arbiter.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/fb_port_arbiter_if.sv
// Framebuffer port bundle: capture write stream, display read stream, BRAM port and status.
// The slave modport is the arbiter side; the master modport is the client/memory side.
interface fb_port_arbiter_if #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 12
);
  logic              i_frame_start;
  logic              i_wr_valid;
  logic [DATA_W-1:0] i_wr_data;
  logic              o_wr_ready;
  logic              i_rd_req;
  logic [ADDR_W-1:0] i_rd_addr;
  logic              o_rd_ready;
  logic              o_rd_valid;
  logic [DATA_W-1:0] o_rd_data;
  logic              o_mem_en;
  logic              o_mem_we;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [DATA_W-1:0] o_mem_wdata;
  logic [DATA_W-1:0] i_mem_rdata;
  logic [ADDR_W-1:0] o_wr_addr;
  logic              o_frame_done;

  modport slave (
    input  i_frame_start, i_wr_valid, i_wr_data, i_rd_req, i_rd_addr, i_mem_rdata,
    output o_wr_ready, o_rd_ready, o_rd_valid, o_rd_data,
           o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata, o_wr_addr, o_frame_done
  );

  modport master (
    output i_frame_start, i_wr_valid, i_wr_data, i_rd_req, i_rd_addr, i_mem_rdata,
    input  o_wr_ready, o_rd_ready, o_rd_valid, o_rd_data,
           o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata, o_wr_addr, o_frame_done
  );
endinterface

// File: rtl/fb_port_arbiter.sv
// Framebuffer BRAM port arbiter: reads win, writes walk a wrapping frame address; command 1 cycle after grant, read data RD_LAT+2 after grant.
// Un-granted side sees ready low and holds; FB_ARB_STARVE_GUARD_EN forces one write after STARVE_MAX blocked cycles.
module fb_port_arbiter #(
  parameter int ADDR_W       = 19,
  parameter int DATA_W       = 12,
  parameter int FRAME_PIXELS = 307200,
  parameter int RD_LAT       = 1,
  parameter int STARVE_MAX   = 8
) (
  input logic              i_sysclk,
  input logic              i_rstn,
  fb_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CMD_RD, CMD_WR} cmd_e;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIXELS - 1);
  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  cmd_e              state_q, state_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic              frame_done_q, frame_done_d;
  logic [RD_LAT:0]   rd_pipe_q, rd_pipe_d;
  logic              rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;

  logic              force_wr;
  logic              rd_grant;
  logic              wr_grant;
  logic [ADDR_W-1:0] wr_base;

  assign rd_grant = i_rstn & bus.i_rd_req & ~force_wr;
  assign wr_grant = i_rstn & bus.i_wr_valid & ~rd_grant;

  assign bus.o_rd_ready = i_rstn & ~force_wr;
  assign bus.o_wr_ready = i_rstn & ~(bus.i_rd_req & ~force_wr);

`ifdef FB_ARB_STARVE_GUARD_EN
  logic [CNT_W-1:0] starve_q, starve_d;

  // Reaching the limit grants the write, which clears the count: force lasts one cycle.
  assign force_wr = bus.i_wr_valid & (starve_q == CNT_W'(STARVE_MAX));

  always_comb begin
    starve_d = '0;
    if (bus.i_wr_valid && !wr_grant) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge i_sysclk or negedge i_rstn) begin
    if (!i_rstn) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  assign force_wr = 1'b0;
`endif

  always_comb begin
    state_d      = IDLE;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    wr_base      = bus.i_frame_start ? '0 : wr_addr_q;
    wr_addr_d    = wr_base;
    frame_done_d = 1'b0;

    if (rd_grant) begin
      state_d    = CMD_RD;
      mem_addr_d = bus.i_rd_addr;
    end else if (wr_grant) begin
      state_d     = CMD_WR;
      mem_addr_d  = wr_base;
      mem_wdata_d = bus.i_wr_data;
      if (wr_base == LAST_ADDR) begin
        wr_addr_d    = '0;
        frame_done_d = 1'b1;
      end else begin
        wr_addr_d = wr_base + 1'b1;
      end
    end

    // Bit k set means the read command went out k cycles ago; the tail lines up with BRAM data.
    rd_pipe_d  = {rd_pipe_q[RD_LAT-1:0], rd_grant};
    rd_valid_d = rd_pipe_q[RD_LAT];
    rd_data_d  = rd_pipe_q[RD_LAT] ? bus.i_mem_rdata : rd_data_q;
  end

  always_ff @(posedge i_sysclk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q      <= IDLE;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      wr_addr_q    <= '0;
      frame_done_q <= 1'b0;
      rd_pipe_q    <= '0;
      rd_valid_q   <= 1'b0;
      rd_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      wr_addr_q    <= wr_addr_d;
      frame_done_q <= frame_done_d;
      rd_pipe_q    <= rd_pipe_d;
      rd_valid_q   <= rd_valid_d;
      rd_data_q    <= rd_data_d;
    end
  end

  assign bus.o_mem_en     = (state_q != IDLE);
  assign bus.o_mem_we     = (state_q == CMD_WR);
  assign bus.o_mem_addr   = mem_addr_q;
  assign bus.o_mem_wdata  = mem_wdata_q;
  assign bus.o_wr_addr    = wr_addr_q;
  assign bus.o_frame_done = frame_done_q;
  assign bus.o_rd_valid   = rd_valid_q;
  assign bus.o_rd_data    = rd_data_q;

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Directed bench for fb_port_arbiter with a 1-cycle BRAM model; frame is scaled to 128 pixels
// so the wrap and the address-100 frame_start case are reachable by real writes.
module tb_fb_port_arbiter;

  localparam int ADDR_W = 19;
  localparam int DATA_W = 12;
  localparam int FRAME  = 128;

`ifdef FB_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic clk;
  logic rstn;
  int   ntests;
  int   nfail;
  int   nwr;

  fb_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  fb_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FRAME_PIXELS(FRAME), .RD_LAT(1), .STARVE_MAX(8)
  ) dut (
    .i_sysclk(clk),
    .i_rstn  (rstn),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DATA_W-1:0] mem [0:FRAME-1];

  always @(posedge clk) begin
    if (bus.o_mem_en) begin
      if (bus.o_mem_we) mem[bus.o_mem_addr[6:0]] <= bus.o_mem_wdata;
      else              bus.i_mem_rdata <= mem[bus.o_mem_addr[6:0]];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp)
    else begin
      nfail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    ntests = 0;
    nfail  = 0;
    nwr    = 0;
    rstn   = 1'b0;
    bus.i_frame_start = 1'b0;
    bus.i_wr_valid    = 1'b1;
    bus.i_wr_data     = '0;
    bus.i_rd_req      = 1'b1;
    bus.i_rd_addr     = '0;

    // Reset: outputs at reset values, readies held low despite requests.
    tick();
    tick();
    chk("rst_mem_en",     32'(bus.o_mem_en), 32'd0);
    chk("rst_mem_we",     32'(bus.o_mem_we), 32'd0);
    chk("rst_mem_addr",   32'(bus.o_mem_addr), 32'd0);
    chk("rst_mem_wdata",  32'(bus.o_mem_wdata), 32'd0);
    chk("rst_rd_valid",   32'(bus.o_rd_valid), 32'd0);
    chk("rst_rd_data",    32'(bus.o_rd_data), 32'd0);
    chk("rst_wr_addr",    32'(bus.o_wr_addr), 32'd0);
    chk("rst_frame_done", 32'(bus.o_frame_done), 32'd0);
    chk("rst_wr_ready",   32'(bus.o_wr_ready), 32'd0);
    chk("rst_rd_ready",   32'(bus.o_rd_ready), 32'd0);
    bus.i_wr_valid = 1'b0;
    bus.i_rd_req   = 1'b0;
    rstn = 1'b1;
    tick();

    // Five back-to-back writes 0x001..0x005 land at addresses 0..4.
    for (int i = 0; i < 5; i++) begin
      bus.i_wr_valid = 1'b1;
      bus.i_wr_data  = 12'(i + 1);
      #1;
      chk("wr_ready", 32'(bus.o_wr_ready), 32'd1);
      tick();
      chk("wr_cmd_en",    32'(bus.o_mem_en), 32'd1);
      chk("wr_cmd_we",    32'(bus.o_mem_we), 32'd1);
      chk("wr_cmd_addr",  32'(bus.o_mem_addr), 32'(i));
      chk("wr_cmd_wdata", 32'(bus.o_mem_wdata), 32'(i + 1));
    end
    chk("wr_addr_after5", 32'(bus.o_wr_addr), 32'd5);

    // Fill addresses 5..99, with 0xABC at address 7.
    for (int a = 5; a < 100; a++) begin
      bus.i_wr_data = (a == 7) ? 12'hABC : 12'(a);
      tick();
    end
    bus.i_wr_valid = 1'b0;
    tick();
    chk("idle_mem_en", 32'(bus.o_mem_en), 32'd0);
    chk("wr_addr_100", 32'(bus.o_wr_addr), 32'd100);

    // frame_start coincident with a write: write goes to 0, next address 1.
    bus.i_frame_start = 1'b1;
    bus.i_wr_valid    = 1'b1;
    bus.i_wr_data     = 12'h055;
    tick();
    bus.i_frame_start = 1'b0;
    bus.i_wr_valid    = 1'b0;
    chk("fs_wr_addr_cmd", 32'(bus.o_mem_addr), 32'd0);
    chk("fs_wr_we",       32'(bus.o_mem_we), 32'd1);
    chk("fs_next_addr",   32'(bus.o_wr_addr), 32'd1);
    chk("fs_frame_done",  32'(bus.o_frame_done), 32'd0);

    // frame_start alone: address resets, no frame_done.
    bus.i_frame_start = 1'b1;
    tick();
    bus.i_frame_start = 1'b0;
    chk("fs_only_addr", 32'(bus.o_wr_addr), 32'd0);
    chk("fs_only_done", 32'(bus.o_frame_done), 32'd0);
    chk("fs_only_en",   32'(bus.o_mem_en), 32'd0);

    // Single read of address 7: command at N+1, data at N+3.
    bus.i_rd_req  = 1'b1;
    bus.i_rd_addr = 19'd7;
    #1;
    chk("rd_ready",        32'(bus.o_rd_ready), 32'd1);
    chk("rd_blocks_wrrdy", 32'(bus.o_wr_ready), 32'd0);
    tick();
    bus.i_rd_req = 1'b0;
    chk("rd_cmd_en",   32'(bus.o_mem_en), 32'd1);
    chk("rd_cmd_we",   32'(bus.o_mem_we), 32'd0);
    chk("rd_cmd_addr", 32'(bus.o_mem_addr), 32'd7);
    chk("rd_vld_n1",   32'(bus.o_rd_valid), 32'd0);
    tick();
    chk("rd_vld_n2",   32'(bus.o_rd_valid), 32'd0);
    tick();
    chk("rd_vld_n3",   32'(bus.o_rd_valid), 32'd1);
    chk("rd_data_n3",  32'(bus.o_rd_data), 32'h0ABC);
    tick();
    chk("rd_vld_n4",   32'(bus.o_rd_valid), 32'd0);

    // Back-to-back reads (7 then 0) give back-to-back valids.
    bus.i_rd_req  = 1'b1;
    bus.i_rd_addr = 19'd7;
    tick();
    bus.i_rd_addr = 19'd0;
    tick();
    bus.i_rd_req = 1'b0;
    tick();
    chk("b2b_vld0",  32'(bus.o_rd_valid), 32'd1);
    chk("b2b_data0", 32'(bus.o_rd_data), 32'h0ABC);
    tick();
    chk("b2b_vld1",  32'(bus.o_rd_valid), 32'd1);
    chk("b2b_data1", 32'(bus.o_rd_data), 32'h055);
    tick();
    chk("b2b_vld2",  32'(bus.o_rd_valid), 32'd0);

    // Wrap: fill 0..FRAME-3, then FRAME-2, FRAME-1, 0 with a single frame_done.
    bus.i_wr_valid = 1'b1;
    for (int a = 0; a < FRAME - 2; a++) begin
      bus.i_wr_data = 12'(a);
      tick();
    end
    bus.i_wr_data = 12'h7E7;
    tick();
    chk("wrap_addr_m2", 32'(bus.o_mem_addr), 32'(FRAME - 2));
    chk("wrap_done_m2", 32'(bus.o_frame_done), 32'd0);
    tick();
    chk("wrap_addr_m1", 32'(bus.o_mem_addr), 32'(FRAME - 1));
    chk("wrap_done_m1", 32'(bus.o_frame_done), 32'd1);
    tick();
    bus.i_wr_valid = 1'b0;
    chk("wrap_addr_0",  32'(bus.o_mem_addr), 32'd0);
    chk("wrap_done_0",  32'(bus.o_frame_done), 32'd0);
    chk("wrap_next",    32'(bus.o_wr_addr), 32'd1);
    tick();
    chk("wrap_done_idle", 32'(bus.o_frame_done), 32'd0);

    // Contention for 20 cycles: guard grants writes on cycles 9 and 18 only.
    bus.i_rd_req   = 1'b1;
    bus.i_rd_addr  = 19'd7;
    bus.i_wr_valid = 1'b1;
    bus.i_wr_data  = 12'h3C3;
    for (int c = 1; c <= 20; c++) begin
      #1;
      chk("cont_wr_ready", 32'(bus.o_wr_ready), 32'(GUARD && (c == 9 || c == 18)));
      chk("cont_rd_ready", 32'(bus.o_rd_ready), 32'(!(GUARD && (c == 9 || c == 18))));
      if (bus.o_wr_ready) nwr++;
      tick();
      chk("cont_mem_we", 32'(bus.o_mem_we), 32'(GUARD && (c == 9 || c == 18)));
    end
    chk("cont_wr_count", 32'(nwr), GUARD ? 32'd2 : 32'd0);
    bus.i_rd_req   = 1'b0;
    bus.i_wr_valid = 1'b0;
    for (int i = 0; i < 6; i++) tick();

    // Reset one cycle after a read grant discards the in-flight read.
    bus.i_rd_req = 1'b1;
    tick();
    bus.i_rd_req = 1'b0;
    rstn = 1'b0;
    #1;
    chk("mid_rst_mem_en",    32'(bus.o_mem_en), 32'd0);
    chk("mid_rst_mem_we",    32'(bus.o_mem_we), 32'd0);
    chk("mid_rst_mem_addr",  32'(bus.o_mem_addr), 32'd0);
    chk("mid_rst_mem_wdata", 32'(bus.o_mem_wdata), 32'd0);
    chk("mid_rst_rd_valid",  32'(bus.o_rd_valid), 32'd0);
    chk("mid_rst_rd_data",   32'(bus.o_rd_data), 32'd0);
    chk("mid_rst_wr_addr",   32'(bus.o_wr_addr), 32'd0);
    chk("mid_rst_done",      32'(bus.o_frame_done), 32'd0);
    tick();
    rstn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("post_rst_no_vld", 32'(bus.o_rd_valid), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
